// File: rtl/ram_dp_param.sv
// Dual-port byte-writable RAM with a self-clearing INIT phase and a 1- or
// 2-stage registered read path with optional write-to-read forwarding.
module ram_dp_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 1,
  parameter int BYPASS     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    wr_enb,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_enb,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    init_busy
);

  localparam int          DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  typedef enum logic {INIT, RUN} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_ptr, w_ptr_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_run, w_wr, w_rd, w_clr_wr;
  logic [DATA_WIDTH-1:0] w_mask, w_wr_word, w_rd_word;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    if (clr) begin
      w_state_nxt = INIT;
      w_ptr_nxt   = '0;
    end else begin
      case (r_state)
        INIT: begin
          w_ptr_nxt = r_ptr + 1'b1;
          if (r_ptr == '1) w_state_nxt = RUN;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  assign w_run     = (r_state == RUN);
  assign w_wr      = w_run & wr_enb & ~clr;
  assign w_rd      = w_run & rd_enb & ~clr;
  assign w_clr_wr  = (r_state == INIT) & ~clr;
  assign init_busy = (r_state == INIT);

  always_comb begin
    w_mask = '0;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      w_mask[8*b +: 8] = {8{wr_be[b]}};
    end
  end

  // Merged word is both what gets stored and what a colliding read forwards.
  assign w_wr_word = (r_mem[wr_addr] & ~w_mask) | (wr_data & w_mask);
  assign w_rd_word = ((BYPASS != 0) && w_wr && (wr_addr == rd_addr)) ? w_wr_word
                                                                     : r_mem[rd_addr];

  always_ff @(posedge clk) begin
    if (w_clr_wr) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr) begin
      r_mem[wr_addr] <= w_wr_word;
    end
  end

  generate
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH <= 0) begin : g_bad_width
      $error("ram_dp_param: DATA_WIDTH must be a positive multiple of 8");
    end

    if (RD_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rd_valid <= 1'b0;
          r_rd_data  <= '0;
        end else if (clr) begin
          r_rd_valid <= 1'b0;
          r_rd_data  <= '0;
        end else begin
          r_rd_valid <= w_rd;
          if (w_rd) r_rd_data <= w_rd_word;
        end
      end
    end else if (RD_LATENCY == 2) begin : g_lat2
      logic                  r_s1_valid;
      logic [DATA_WIDTH-1:0] r_s1_data;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s1_valid <= 1'b0;
          r_s1_data  <= '0;
          r_rd_valid <= 1'b0;
          r_rd_data  <= '0;
        end else if (clr) begin
          r_s1_valid <= 1'b0;
          r_s1_data  <= '0;
          r_rd_valid <= 1'b0;
          r_rd_data  <= '0;
        end else begin
          r_s1_valid <= w_rd;
          if (w_rd) r_s1_data <= w_rd_word;
          r_rd_valid <= r_s1_valid;
          if (r_s1_valid) r_rd_data <= r_s1_data;
        end
      end
    end else begin : g_bad_latency
      $error("ram_dp_param: RD_LATENCY must be 1 or 2");
    end
  endgenerate

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_ram_dp_param.sv
// Scoreboard bench: instance A uses defaults (8-bit, latency 1, forwarding),
// instance B is 32-bit, latency 2, old-data read; both share one stimulus stream.
module tb_ram_dp_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        wr_enb = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_enb = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic [7:0]  rdA;
  logic        rvA, busyA;
  logic [31:0] rdB;
  logic        rvB, busyB;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_dp_param u_dut_a (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data[7:0]), .wr_be(wr_be[0]),
    .rd_enb(rd_enb), .rd_addr(rd_addr),
    .rd_data(rdA), .rd_valid(rvA), .init_busy(busyA)
  );

  ram_dp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(2), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_enb(rd_enb), .rd_addr(rd_addr),
    .rd_data(rdB), .rd_valid(rvB), .init_busy(busyB)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: pops expectations on every valid pulse, checks data and arrival cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (busyA) check("init_quiet_a", {rdA, 23'h0, rvA}, 32'h0);
      if (busyB) check("init_quiet_b", rdB | {31'h0, rvB}, 32'h0);
      if (rvA) begin
        if (qa.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_valid_a: got rd_valid=1 data %h expected no valid (cycle %0d)", rdA, cyc);
        end else begin
          e = qa.pop_front();
          check("rd_data_a", {24'h0, rdA}, e.data);
          check("rd_time_a", cyc, e.due);
        end
      end
      if (rvB) begin
        if (qb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_valid_b: got rd_valid=1 data %h expected no valid (cycle %0d)", rdB, cyc);
        end else begin
          e = qb.pop_front();
          check("rd_data_b", rdB, e.data);
          check("rd_time_b", cyc, e.due);
        end
      end
    end
  end

  // Called at a negedge; the operation takes effect on the following posedge.
  task automatic op(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                    input logic [3:0] wbe, input logic re, input logic [3:0] ra,
                    input logic [7:0] ea, input logic [31:0] eb, input bit pb);
    wr_enb = we; wr_addr = wa; wr_data = wd; wr_be = wbe;
    rd_enb = re; rd_addr = ra;
    if (re) begin
      qa.push_back('{data: {24'h0, ea}, due: cyc + 1});
      if (pb) qb.push_back('{data: eb, due: cyc + 2});
    end
    @(negedge clk);
    wr_enb = 1'b0; rd_enb = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    op(1'b1, a, d, be, 1'b0, 4'h0, 8'h0, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] ea, input logic [31:0] eb);
    op(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, a, ea, eb, 1'b1);
  endtask

  task automatic wait_init(input string name);
    int cnt;
    cnt = 0;
    while (busyA && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check(name, cnt, 16);
    check({name, "_b"}, {31'h0, busyB}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected completion within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_a", {rdA, 22'h0, rvA, busyA}, 32'h1);
    check("reset_b", rdB, 32'h0);
    check("reset_vb", {30'h0, rvB, busyB}, 32'h1);
    rst = 1'b0;
    wait_init("init_cycles");

    // Every location reads zero after clear, one pulse per read, back to back.
    for (int i = 0; i < 16; i++) rd(4'(i), 8'h00, 32'h0);
    repeat (3) @(negedge clk);

    // Byte-lane writes.
    wr(4'd3, 32'hAABBCCDD, 4'hF);
    wr(4'd3, 32'h11223344, 4'b0101);
    rd(4'd3, 8'h44, 32'hAA22CC44);
    wr(4'd3, 32'hFFFFFFFF, 4'h0);
    rd(4'd3, 8'h44, 32'hAA22CC44);

    // Same-address collision: forwarding on A, old data on B.
    wr(4'd5, 32'h10, 4'hF);
    op(1'b1, 4'd5, 32'h5A, 4'hF, 1'b1, 4'd5, 8'h5A, 32'h10, 1'b1);
    rd(4'd5, 8'h5A, 32'h5A);

    // Consecutive reads at full throughput.
    wr(4'd0, 32'h01, 4'hF);
    wr(4'd1, 32'h02, 4'hF);
    wr(4'd2, 32'h03, 4'hF);
    rd(4'd0, 8'h01, 32'h01);
    rd(4'd1, 8'h02, 32'h02);
    rd(4'd2, 8'h03, 32'h03);
    repeat (4) @(negedge clk);
    check("hold_a", {24'h0, rdA}, 32'h03);
    check("hold_b", rdB, 32'h03);

    // clr with a concurrent write and a B read still in flight.
    wr(4'd7, 32'hFF, 4'hF);
    op(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd7, 8'hFF, 32'h0, 1'b0);
    clr = 1'b1; wr_enb = 1'b1; wr_addr = 4'd8; wr_data = 32'h77; wr_be = 4'hF;
    rd_enb = 1'b1; rd_addr = 4'd7;
    @(negedge clk);
    clr = 1'b0; wr_enb = 1'b0; rd_enb = 1'b0;
    check("clr_rdata_a", {24'h0, rdA}, 32'h0);
    check("clr_rdata_b", rdB, 32'h0);
    check("clr_busy", {30'h0, busyA, busyB}, 32'h3);
    wr_enb = 1'b1; wr_addr = 4'd9; wr_data = 32'h99; wr_be = 4'hF;
    rd_enb = 1'b1; rd_addr = 4'd9;
    wait_init("clr_init_cycles");
    wr_enb = 1'b0; rd_enb = 1'b0;
    rd(4'd7, 8'h00, 32'h0);
    rd(4'd8, 8'h00, 32'h0);
    rd(4'd9, 8'h00, 32'h0);
    rd(4'd5, 8'h00, 32'h0);
    repeat (3) @(negedge clk);

    // Async reset mid-read.
    wr(4'd5, 32'h5A, 4'hF);
    wr(4'd0, 32'h01, 4'hF);
    rd_enb = 1'b1; rd_addr = 4'd5;
    qa.push_back('{data: 32'h5A, due: cyc + 1});
    qb.push_back('{data: 32'h5A, due: cyc + 2});
    @(negedge clk);
    rd_addr = 4'd0;
    qa.push_back('{data: 32'h01, due: cyc + 1});
    @(posedge clk);
    #2;
    rd_enb = 1'b0;
    check("pre_rst_a", {24'h0, rdA}, 32'h01);
    check("pre_rst_b", rdB, 32'h5A);
    rst = 1'b1;
    qa.delete();
    qb.delete();
    #1;
    check("async_rst_a", {rdA, 22'h0, rvA, busyA}, 32'h1);
    check("async_rst_b", rdB | {30'h0, rvB, ~busyB}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_init("rst_run_init_cycles");

    // Async reset mid-clear at ptr 9.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_clear_busy", {30'h0, busyA, busyB}, 32'h3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_clear", {rdA, 22'h0, rvA, busyA}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    wait_init("rst_clear_init_cycles");
    rd(4'd5, 8'h00, 32'h0);
    wr(4'd15, 32'hC3C3C3C3, 4'b1001);
    rd(4'd15, 8'hC3, 32'hC30000C3);
    repeat (4) @(negedge clk);

    check("queue_a_empty", qa.size(), 32'h0);
    check("queue_b_empty", qb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
